nand_reset_seq: RTL

- Drives the NAND device reset sequence once the PHY reset (rstn0) is released.
- After a power-on settle wait, issues the ONFI RESET command (FFh) as one asynchronous-mode command latch cycle.
- Then polls R/B# until the device reports ready, or until a timeout expires.
- Sits in the clk0 domain between the infrastructure block and the NAND PHY; its pins are muxed onto the bus before any other controller traffic.

---
 rtl/nand_phy_pkg.sv | 47 ++++
 rtl/nand_sync2.sv | 23 ++
 rtl/nand_reset_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/nand_phy_pkg.sv
// Shared NAND PHY definitions: sequencer states, ONFI command bytes, default timings.
package nand_phy_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POR_WAIT,
        ST_CMD_SETUP,
        ST_WE_LOW,
        ST_WE_HIGH,
        ST_WB_WAIT,
        ST_POLL,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] ONFI_CMD_RESET       = 8'hFF;
    localparam logic [7:0] ONFI_CMD_READ_ID     = 8'h90;
    localparam logic [7:0] ONFI_CMD_READ_STATUS = 8'h70;
    localparam logic [7:0] ONFI_CMD_READ_PARAM  = 8'hEC;

    localparam int unsigned DEF_POR_WAIT_CYC = 100;
    localparam int unsigned DEF_T_CS_CYC     = 2;
    localparam int unsigned DEF_T_WP_CYC     = 2;
    localparam int unsigned DEF_T_WH_CYC     = 2;
    localparam int unsigned DEF_T_WB_CYC     = 10;
    localparam int unsigned DEF_TIMEOUT_CYC  = 100000;

    // NAND pin bundle driven towards the PHY.
    typedef struct packed {
        logic       ce_n;
        logic       cle;
        logic       ale;
        logic       we_n;
        logic       re_n;
        logic       wp_n;
        logic [7:0] dq_out;
        logic       dq_oe;
    } nand_bus_t;

    localparam nand_bus_t BUS_IDLE = '{ce_n: 1'b1, cle: 1'b0, ale: 1'b0, we_n: 1'b1,
                                       re_n: 1'b1, wp_n: 1'b0, dq_out: 8'h00, dq_oe: 1'b0};

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nand_sync2.sv
// Two-flop synchronizer for asynchronous NAND pins, with selectable reset value.
module nand_sync2 #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nand_reset_seq.sv
// NAND power-on reset sequencer: settle wait, one async RESET (FFh) command latch, R/B# poll.
module nand_reset_seq
    import nand_phy_pkg::*;
#(
    parameter int unsigned POR_WAIT_CYC = DEF_POR_WAIT_CYC,
    parameter int unsigned T_CS_CYC     = DEF_T_CS_CYC,
    parameter int unsigned T_WP_CYC     = DEF_T_WP_CYC,
    parameter int unsigned T_WH_CYC     = DEF_T_WH_CYC,
    parameter int unsigned T_WB_CYC     = DEF_T_WB_CYC,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter bit          AUTO_START   = 1'b1,
    parameter logic [7:0]  CMD_RESET    = ONFI_CMD_RESET
) (
    input  logic       clk0,
    input  logic       rstn0,
    input  logic       start,
    input  logic       rb_n,
    output logic       ce_n,
    output logic       cle,
    output logic       ale,
    output logic       we_n,
    output logic       re_n,
    output logic       wp_n,
    output logic [7:0] dq_out,
    output logic       dq_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(POR_WAIT_CYC, T_CS_CYC),
                                                  max_u(T_WP_CYC, T_WH_CYC)),
                                            max_u(T_WB_CYC, TIMEOUT_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             first;
    logic             rb_s;
    nand_bus_t        bus_q, bus_nxt;
    logic             busy_nxt, done_nxt, err_nxt;

    nand_sync2 #(.RST_VAL(1'b1)) u_rb_sync (
        .clk   (clk0),
        .rst_n (rstn0),
        .d     (rb_n),
        .q     (rb_s)
    );

    // Count preload on entry: N-1 so a timed state spans exactly N cycles.
    function automatic logic [CNT_W-1:0] load_of(input state_t s);
        case (s)
            ST_POR_WAIT:  return CNT_W'(POR_WAIT_CYC - 1);
            ST_CMD_SETUP: return CNT_W'(T_CS_CYC - 1);
            ST_WE_LOW:    return CNT_W'(T_WP_CYC - 1);
            ST_WE_HIGH:   return CNT_W'(T_WH_CYC - 1);
            ST_WB_WAIT:   return CNT_W'(T_WB_CYC - 1);
            ST_POLL:      return CNT_W'(TIMEOUT_CYC - 1);
            default:      return '0;
        endcase
    endfunction

    always_ff @(posedge clk0 or negedge rstn0) begin
        if (!rstn0) begin
            state <= ST_IDLE;
            cnt   <= '0;
            first <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            first <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        unique case (state)
            ST_IDLE:      if (start || (AUTO_START && first)) state_nxt = ST_POR_WAIT;
            ST_POR_WAIT:  if (cnt == '0) state_nxt = ST_CMD_SETUP;
            ST_CMD_SETUP: if (cnt == '0) state_nxt = ST_WE_LOW;
            ST_WE_LOW:    if (cnt == '0) state_nxt = ST_WE_HIGH;
            ST_WE_HIGH:   if (cnt == '0) state_nxt = ST_WB_WAIT;
            ST_WB_WAIT:   if (cnt == '0) state_nxt = ST_POLL;
            ST_POLL: begin
                // Ready wins over a timeout expiring on the same cycle.
                if (rb_s)            state_nxt = ST_DONE;
                else if (cnt == '0)  state_nxt = ST_ERR;
            end
            ST_DONE, ST_ERR: if (start) state_nxt = ST_POR_WAIT;
            default:      state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = load_of(state_nxt);
    end

    // Outputs decoded from the next state and registered, so pins align with state.
    always_comb begin
        bus_nxt  = BUS_IDLE;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state_nxt)
            ST_POR_WAIT: begin
                bus_nxt.wp_n = 1'b1;
                busy_nxt     = 1'b1;
            end
            ST_CMD_SETUP, ST_WE_LOW, ST_WE_HIGH: begin
                bus_nxt.wp_n   = 1'b1;
                bus_nxt.ce_n   = 1'b0;
                bus_nxt.cle    = 1'b1;
                bus_nxt.dq_oe  = 1'b1;
                bus_nxt.dq_out = CMD_RESET;
                bus_nxt.we_n   = (state_nxt != ST_WE_LOW);
                busy_nxt       = 1'b1;
            end
            ST_WB_WAIT, ST_POLL: begin
                bus_nxt.wp_n = 1'b1;
                bus_nxt.ce_n = 1'b0;
                busy_nxt     = 1'b1;
            end
            ST_DONE: begin
                bus_nxt.wp_n = 1'b1;
                done_nxt     = 1'b1;
            end
            ST_ERR: begin
                bus_nxt.wp_n = 1'b1;
                err_nxt      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk0 or negedge rstn0) begin
        if (!rstn0) begin
            bus_q <= BUS_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            bus_q <= bus_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    assign ce_n   = bus_q.ce_n;
    assign cle    = bus_q.cle;
    assign ale    = bus_q.ale;
    assign we_n   = bus_q.we_n;
    assign re_n   = bus_q.re_n;
    assign wp_n   = bus_q.wp_n;
    assign dq_out = bus_q.dq_out;
    assign dq_oe  = bus_q.dq_oe;

endmodule
